btn_debounce: RTL and testbench
===============================

# btn_debounce

Upstream input stage for the SoC's push-button. It synchronises the raw asynchronous `btn` pin into the `original_clk` domain and rejects contact bounce. It then emits a clean level plus single-cycle press/release strobes, which the core samples through its GPIO input register. The SoC top instantiates it between the board pin and the core.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
- `LONG_CYCLES`, default 1024: cycles in the held state before a long-press strobe; used only when `BTN_LONG_PRESS_EN` is defined.

Ports:
- `original_clk`  in  1  system clock; single clock domain.
- `original_rst`  in  1  reset, synchronous, active-high.
- `btn`  in  1  raw board button, asynchronous, may bounce.
- `btn_level`  out  1  debounced button level.
- `btn_press`  out  1  one-cycle strobe on accepted 0→1.
- `btn_release`  out  1  one-cycle strobe on accepted 1→0.
- `btn_long`  out  1  one-cycle strobe on long press; tied 0 when the feature is compiled out.

## Operation
- Synchroniser: two flops, `s1 <= btn`, `s2 <= s1`; both reset to 0. The FSM sees only `s2`.
- FSM states: IDLE (stable low), RISE (qualifying high), HELD (stable high), FALL (qualifying low).
- IDLE: if `s2`=1 → RISE, `cnt`←0.
- RISE:
  - `s2`=0 → IDLE; the glitch is rejected and no strobe is issued.
  - `s2`=1 and `cnt`==DEBOUNCE_CYCLES-1 → HELD; `btn_level`←1; `btn_press` pulses.
  - Otherwise `cnt`++.
- HELD: if `s2`=0 → FALL, `cnt`←0.
- FALL:
  - `s2`=1 → HELD; the glitch is rejected.
  - `s2`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE; `btn_level`←0; `btn_release` pulses.
  - Otherwise `cnt`++.
- `cnt` width is `$clog2(DEBOUNCE_CYCLES)`. The count never wraps because the terminal compare always exits the state.
- `btn_level` changes only on HELD/IDLE entry. Bounce inside RISE or FALL never toggles it.
- `btn_press` and `btn_release` are mutually exclusive. Neither can assert in consecutive cycles: at least DEBOUNCE_CYCLES cycles separate them.
- Reset mid-operation: state→IDLE, `cnt`→0, synchroniser→0, all outputs→0 on the next edge. A button held through reset is re-qualified after reset deasserts, and `btn_press` fires again.

## Timing
- Reset values: `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_long`=0, state=IDLE.
- All outputs are registered; there are no combinational paths from `btn`.
- Press latency:
  - `btn` is first sampled high at edge k and stays stable.
  - `s2`=1 after edge k+1; RISE is entered at edge k+2.
  - HELD is entered at edge k+2+DEBOUNCE_CYCLES.
  - `btn_level` and `btn_press` are high in the cycle following that edge; `btn_press` lasts exactly 1 cycle.
- Release latency is identical: DEBOUNCE_CYCLES+2 edges.
- A pulse that is high for fewer than DEBOUNCE_CYCLES consecutive `s2` samples produces no strobe.

## Configuration
- Macro `BTN_LONG_PRESS_EN`.
- Defined:
  - A `lcnt` counter, width `$clog2(LONG_CYCLES+1)`, clears on HELD entry and increments each cycle in HELD or FALL.
  - When `lcnt` reaches LONG_CYCLES, `btn_long` pulses for 1 cycle and `lcnt` saturates. This gives exactly one strobe per press.
  - A FALL→HELD glitch return does not clear `lcnt`.
  - `btn_release` still pulses on the later release.
- Undefined: no `lcnt` logic; `btn_long` is driven constant 0. The port remains, so the top-level wiring is unchanged.

## Structure
- The shared SoC package holds:
  - FSM state encodings (2-bit: IDLE=0, RISE=1, HELD=2, FALL=3);
  - the default DEBOUNCE_CYCLES and LONG_CYCLES constants.
- One sub-module: `btn_sync2`, the two-flop synchroniser with synchronous reset. It is reused for any future asynchronous GPIO input.
- The FSM, counters and strobe registers live in `btn_debounce`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, macro defined, 2 ns clock.
- Clean press: `btn` 0→1 at edge k and held → `btn_level`=1 and `btn_press`=1 for exactly one cycle after edge k+6; `btn_release` stays 0.
- Bounce rejection: `btn` toggles 1,0,1,0 (one cycle each) then stays 0 → no strobe; `btn_level` stays 0; state returns to IDLE.
- Bouncy press: three 1-cycle glitches, then stable high → exactly one `btn_press`, 6 edges after the start of the final stable high.
- Long press: hold for 40 cycles after HELD entry → `btn_long` pulses once, 21 edges after HELD entry. On release, `btn_release` pulses once, 6 edges after `btn` falls.
- Reset mid-press: assert `original_rst` for 3 cycles while in HELD with `btn`=1 → all outputs 0 the cycle after the first reset edge. After deassert, `btn_press` fires again 6 edges later.
- Macro undefined build: same long-hold stimulus → `btn_long` constant 0; press and release timing unchanged.

Source files
------------

// File: rtl/btn_debounce_pkg.sv
// Shared SoC definitions for the push-button input stage: FSM encodings and
// default timing constants.
package btn_debounce_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRise = 2'd1,
        StHeld = 2'd2,
        StFall = 2'd3
    } btn_state_e;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 1024;

endpackage

// File: rtl/btn_debounce_sync2.sv
// The button input synchroniser is implemented in btn_sync2.sv.

// File: rtl/btn_sync2.sv
// Two-flop synchroniser with synchronous active-high reset, for any
// asynchronous GPIO input entering the system clock domain.
module btn_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchroniser, qualify FSM and registered strobes.
// Optional long-press strobe is compiled in with `define BTN_LONG_PRESS_EN.
module btn_debounce
    import btn_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic original_clk,
    input  logic original_rst,
    input  logic btn,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             s2;
    logic             enter_held;

    btn_sync2 u_sync (
        .clk (original_clk),
        .rst (original_rst),
        .d   (btn),
        .q   (s2)
    );

    // Only a fully qualified rise enters HELD; a FALL glitch return does not count.
    assign enter_held = (state == StRise) && s2 && (cnt == CNT_MAX);

    always_ff @(posedge original_clk) begin
        if (original_rst) begin
            state       <= StIdle;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            case (state)
                StIdle: begin
                    if (s2) begin
                        state <= StRise;
                        cnt   <= '0;
                    end
                end
                StRise: begin
                    if (!s2) begin
                        state <= StIdle;
                    end else if (enter_held) begin
                        state     <= StHeld;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StHeld: begin
                    if (!s2) begin
                        state <= StFall;
                        cnt   <= '0;
                    end
                end
                StFall: begin
                    if (s2) begin
                        state <= StHeld;
                    end else if (cnt == CNT_MAX) begin
                        state       <= StIdle;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned LCNT_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LONG_CYCLES);

    logic [LCNT_W-1:0] lcnt;
    logic              long_fired;

    // lcnt saturates at LONG_CYCLES; long_fired keeps it to one strobe per press.
    always_ff @(posedge original_clk) begin
        if (original_rst) begin
            lcnt       <= '0;
            long_fired <= 1'b0;
            btn_long   <= 1'b0;
        end else begin
            btn_long <= 1'b0;
            if (enter_held) begin
                lcnt       <= '0;
                long_fired <= 1'b0;
            end else if (state == StHeld || state == StFall) begin
                if (lcnt != LCNT_MAX) begin
                    lcnt <= lcnt + 1'b1;
                end else if (!long_fired) begin
                    btn_long   <= 1'b1;
                    long_fired <= 1'b1;
                end
            end
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
`timescale 1ns/1ps
module tb_btn_debounce;

    logic original_clk = 1'b0;
    logic original_rst = 1'b1;
    logic btn          = 1'b0;
    logic btn_level, btn_press, btn_release, btn_long;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef BTN_LONG_PRESS_EN
    localparam int EXP_NLONG = 1;
    localparam int EXP_LONG_AT = 28;
`else
    localparam int EXP_NLONG = 0;
    localparam int EXP_LONG_AT = -1;
`endif

    btn_debounce #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20)
    ) dut (
        .original_clk (original_clk),
        .original_rst (original_rst),
        .btn          (btn),
        .btn_level    (btn_level),
        .btn_press    (btn_press),
        .btn_release  (btn_release),
        .btn_long     (btn_long)
    );

    always #1 original_clk = ~original_clk;

    typedef struct packed {
        logic       rst;
        logic       b;
        logic [3:0] exp; // {level, press, release, long}
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic b, input logic [3:0] e, input int n);
        for (int i = 0; i < n; i++) vt.push_back('{rst: r, b: b, exp: e});
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic b, input logic r);
        btn          = b;
        original_rst = r;
        @(posedge original_clk);
        @(negedge original_clk);
    endtask

    function automatic int outs();
        return int'({btn_level, btn_press, btn_release, btn_long});
    endfunction

    int npress, nrel, nlong, press_at, rel_at, long_at, glitch_hits;

    initial begin
        // Reset, clean press, clean release, then a 1,0,1,0 bounce.
        add(1, 0, 4'b0000, 2);
        add(0, 0, 4'b0000, 1);
        add(0, 1, 4'b0000, 6);
        add(0, 1, 4'b1100, 1);
        add(0, 1, 4'b1000, 3);
        add(0, 0, 4'b1000, 6);
        add(0, 0, 4'b0010, 1);
        add(0, 0, 4'b0000, 1);
        add(0, 1, 4'b0000, 1);
        add(0, 0, 4'b0000, 1);
        add(0, 1, 4'b0000, 1);
        add(0, 0, 4'b0000, 9);

        @(negedge original_clk);
        foreach (vt[i]) begin
            step(vt[i].b, vt[i].rst);
            check($sformatf("vec%0d", i), outs(), int'(vt[i].exp));
        end
        check("bounce_state_idle", int'(dut.state), 0);

        // Bouncy press: three 1-cycle glitches, then stable high for 47 edges.
        glitch_hits = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            glitch_hits += int'(btn_press | btn_level);
            step(0, 0);
            glitch_hits += int'(btn_press | btn_level);
        end
        check("glitch_no_strobe", glitch_hits, 0);

        npress = 0; nrel = 0; nlong = 0; press_at = -1; long_at = -1;
        for (int i = 1; i <= 47; i++) begin
            step(1, 0);
            if (btn_press)   begin npress++; press_at = i; end
            if (btn_long)    begin nlong++;  long_at  = i; end
            if (btn_release) nrel++;
        end
        check("bouncy_npress", npress, 1);
        check("bouncy_press_at", press_at, 7);
        check("long_count", nlong, EXP_NLONG);
        check("long_at", long_at, EXP_LONG_AT);
        check("hold_no_release", nrel, 0);
        check("hold_level", int'(btn_level), 1);

        nrel = 0; rel_at = -1; nlong = 0;
        for (int i = 1; i <= 10; i++) begin
            step(0, 0);
            if (btn_release) begin nrel++; rel_at = i; end
            if (btn_long) nlong++;
        end
        check("release_count", nrel, 1);
        check("release_at", rel_at, 7);
        check("release_no_long", nlong, 0);
        check("release_level", int'(btn_level), 0);

        // Reset while held: outputs clear after the first reset edge, then re-qualify.
        for (int i = 0; i < 10; i++) step(1, 0);
        check("pre_reset_level", int'(btn_level), 1);
        step(1, 1);
        check("reset_outs", outs(), 0);
        step(1, 1);
        step(1, 1);
        check("reset_hold_outs", outs(), 0);
        npress = 0; press_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step(1, 0);
            if (btn_press) begin npress++; press_at = i; end
        end
        check("post_reset_npress", npress, 1);
        check("post_reset_press_at", press_at, 7);
        check("post_reset_level", int'(btn_level), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
